// File: rtl/target_lane_array.sv
// -----------------------------------------------------------------------------
// target_lane_array
//
// Rhythm-game style target lanes. Each lane watches a "note" level from the
// row above (prelight_i) and a player press level (gotcha_i). A note rising
// edge lights the lane's target for WINDOW cycles. A press rising edge while
// lit scores a hit. Letting the window expire scores a miss. Pressing an
// unlit lane is a foul, scored as a miss. A press landing in the same cycle
// as the note edge counts as a perfect hit, and the light never turns on.
// Hits and misses from all lanes are totalled in saturating counters.
//
// Ports
//   clk_i        : clock; all state updates on its rising edge
//   rst_i        : synchronous, active-high reset
//   prelight_i   : [LANES] per-lane note level; a note is a rising edge
//   gotcha_i     : [LANES] per-lane press level; a press is a rising edge
//   lighton_o    : [LANES] registered target light, high while lane is ARMED
//   hit_o        : [LANES] registered one-cycle hit pulse
//   miss_o       : [LANES] registered one-cycle miss pulse (timeout or foul)
//   hitcount_o   : [CNT_W] saturating total of hit pulses over all lanes
//   misscount_o  : [CNT_W] saturating total of miss pulses over all lanes
// -----------------------------------------------------------------------------
module target_lane_array #(
  parameter int LANES  = 4,
  parameter int WINDOW = 3,
  parameter int CNT_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [LANES-1:0] prelight_i,
  input  logic [LANES-1:0] gotcha_i,
  output logic [LANES-1:0] lighton_o,
  output logic [LANES-1:0] hit_o,
  output logic [LANES-1:0] miss_o,
  output logic [CNT_W-1:0] hitcount_o,
  output logic [CNT_W-1:0] misscount_o
);

  // Window counter: one extra bit over clog2 so WINDOW-1 always fits,
  // including WINDOW=1 where the counter is a single bit.
  localparam int CW = $clog2(WINDOW) + 1;
  // Width that holds a popcount of LANES pulses.
  localparam int PC_W = $clog2(LANES + 1);
  // Score sum width: the largest counter value plus a full popcount
  // cannot overflow this, so the saturation compare is always valid.
  localparam int SUM_W = CNT_W + PC_W;

  localparam logic [CW-1:0]    WIN_LOAD = CW'(WINDOW - 1);
  localparam logic [SUM_W-1:0] SAT_MAX  = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Per-lane state
  state_t          state_q [LANES];
  state_t          state_d [LANES];
  logic [CW-1:0]   cnt_q   [LANES];
  logic [CW-1:0]   cnt_d   [LANES];

  // Edge detection: registered copies of the inputs from the previous cycle
  logic [LANES-1:0] prelight_q;
  logic [LANES-1:0] gotcha_q;
  logic [LANES-1:0] note_edge;
  logic [LANES-1:0] press_edge;

  // Registered outputs and their next values
  logic [LANES-1:0] lighton_q, lighton_d;
  logic [LANES-1:0] hit_q,     hit_d;
  logic [LANES-1:0] miss_q,    miss_d;
  logic [CNT_W-1:0] hitcount_q,  hitcount_d;
  logic [CNT_W-1:0] misscount_q, misscount_d;

  assign note_edge  = prelight_i & ~prelight_q;
  assign press_edge = gotcha_i   & ~gotcha_q;

  // Add the number of set bits in pulses to base, clamping at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0] base,
    input logic [LANES-1:0] pulses
  );
    logic [SUM_W-1:0] sum;
    sum = {{PC_W{1'b0}}, base};
    for (int i = 0; i < LANES; i++) begin
      sum = sum + SUM_W'(pulses[i]);
    end
    if (sum > SAT_MAX) begin
      return {CNT_W{1'b1}};
    end
    return sum[CNT_W-1:0];
  endfunction

  // Lane FSMs. Every lane is evaluated independently; nothing in one lane's
  // branch looks at another lane.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    hit_d     = '0;
    miss_d    = '0;
    lighton_d = '0;
    for (int i = 0; i < LANES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (press_edge[i]) begin
            // Press with a simultaneous note is a perfect hit; a press
            // with no note is a foul. Either way the lane stays IDLE.
            hit_d[i]  = note_edge[i];
            miss_d[i] = ~note_edge[i];
          end else if (note_edge[i]) begin
            state_d[i] = ARMED;
            cnt_d[i]   = WIN_LOAD;
          end
        end
        ARMED: begin
          // Note edges are ignored here: the window is never reloaded.
          if (press_edge[i]) begin
            state_d[i] = IDLE;
            hit_d[i]   = 1'b1;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = IDLE;
            miss_d[i]  = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
      lighton_d[i] = (state_d[i] == ARMED);
    end
  end

  // Scores land on the same edge as the pulses that produce them.
  always_comb begin
    hitcount_d  = sat_add(hitcount_q,  hit_d);
    misscount_d = sat_add(misscount_q, miss_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Edge registers reset high so levels already high at release are
      // not mistaken for fresh edges.
      prelight_q  <= '1;
      gotcha_q    <= '1;
      lighton_q   <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
      hitcount_q  <= '0;
      misscount_q <= '0;
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      prelight_q  <= prelight_i;
      gotcha_q    <= gotcha_i;
      lighton_q   <= lighton_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      hitcount_q  <= hitcount_d;
      misscount_q <= misscount_d;
      for (int i = 0; i < LANES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign lighton_o   = lighton_q;
  assign hit_o       = hit_q;
  assign miss_o      = miss_q;
  assign hitcount_o  = hitcount_q;
  assign misscount_o = misscount_q;

endmodule
